// File: rtl/first_stage_quadrant_writer.sv
// rtl/first_stage_quadrant_writer.sv - write-back stage: accumulate, saturate and write quadrant pixels
//
// Purpose: consumes the signed product stream for one quadrant pass. It sums
// ELEMENTS products per output pixel, saturates the sum to 16 bits and writes
// the result at the pixel's full-image address. The loop order is element
// (fastest), then column, then row, then vector.
//
// Optional feature: FIRST_STAGE_RELU_EN. When defined, negative saturated
// results are written as 0.
//
// Ports:
//   clock          in   rising-edge system clock
//   clear          in   asynchronous active-high reset
//   start          in   one-cycle pulse, latches quadrant and begins a pass (IDLE only)
//   quadrant[1:0]  in   bit0 selects the column half, bit1 selects the row half
//   product_data   in   signed product for the current element
//   product_valid  in   product_data is valid
//   product_ready  out  a product is accepted this cycle (RUN)
//   write_address  out  {vector[1:0], 2'b00, row[3:0], col[3:0]}
//   write_data     out  saturated signed pixel result
//   write_en       out  one-cycle write strobe
//   busy           out  high in RUN and FLUSH
//   done           out  one-cycle pulse alongside the final write
module first_stage_quadrant_writer #(
  parameter int ELEMENTS = 9,
  parameter int COLS     = 8,
  parameter int ROWS     = 8,
  parameter int VECTORS  = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [1:0]  quadrant,
  input  logic [15:0] product_data,
  input  logic        product_valid,
  output logic        product_ready,
  output logic [11:0] write_address,
  output logic [15:0] write_data,
  output logic        write_en,
  output logic        busy,
  output logic        done
);

  localparam int ELEM_W = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t              state, state_next;
  logic [ELEM_W-1:0]   elem_cnt;
  logic [3:0]          col_cnt;
  logic [3:0]          row_cnt;
  logic [1:0]          vec_cnt;
  logic [1:0]          quad_q;
  logic signed [23:0]  acc;

  logic                accept;
  logic                last_elem, last_col, last_row, last_vec;
  logic                final_accept;
  logic signed [23:0]  sum;
  logic [15:0]         sat;
  logic [15:0]         result;
  logic [3:0]          col_addr;
  logic [3:0]          row_addr;

  assign accept       = product_valid && (state == RUN);
  assign last_elem    = (elem_cnt == ELEM_W'(ELEMENTS - 1));
  assign last_col     = (col_cnt == 4'(COLS - 1));
  assign last_row     = (row_cnt == 4'(ROWS - 1));
  assign last_vec     = (vec_cnt == 2'(VECTORS - 1));
  assign final_accept = accept && last_elem && last_col && last_row && last_vec;

  // Quadrant offsets place the local pixel in the full image.
  assign col_addr = (quad_q[0] ? 4'(COLS) : 4'd0) + col_cnt;
  assign row_addr = (quad_q[1] ? 4'(ROWS) : 4'd0) + row_cnt;

  always_comb begin
    sum = acc + {{8{product_data[15]}}, product_data};
    if (sum > 24'sd32767) begin
      sat = 16'h7FFF;
    end else if (sum < -24'sd32768) begin
      sat = 16'h8000;
    end else begin
      sat = sum[15:0];
    end
`ifdef FIRST_STAGE_RELU_EN
    result = sat[15] ? 16'h0000 : sat;
`else
    result = sat;
`endif
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    product_ready = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        product_ready = 1'b1;
        busy          = 1'b1;
        if (final_accept) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        // The final write is already on the write port this cycle.
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      elem_cnt      <= '0;
      col_cnt       <= '0;
      row_cnt       <= '0;
      vec_cnt       <= '0;
      quad_q        <= '0;
      acc           <= '0;
      write_en      <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
    end else begin
      write_en <= 1'b0;
      if ((state == IDLE) && start) begin
        quad_q   <= quadrant;
        elem_cnt <= '0;
        col_cnt  <= '0;
        row_cnt  <= '0;
        vec_cnt  <= '0;
        acc      <= '0;
      end else if (accept) begin
        if (last_elem) begin
          // Pixel complete: register the write and restart the accumulator so
          // the next pixel's first product can follow without a bubble.
          acc           <= '0;
          write_en      <= 1'b1;
          write_data    <= result;
          write_address <= {vec_cnt, 2'b00, row_addr, col_addr};
          elem_cnt      <= '0;
          if (last_col) begin
            col_cnt <= '0;
            if (last_row) begin
              row_cnt <= '0;
              vec_cnt <= last_vec ? 2'd0 : vec_cnt + 2'd1;
            end else begin
              row_cnt <= row_cnt + 4'd1;
            end
          end else begin
            col_cnt <= col_cnt + 4'd1;
          end
        end else begin
          acc      <= sum;
          elem_cnt <= elem_cnt + ELEM_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_first_stage_quadrant_writer.sv
// tb/tb_first_stage_quadrant_writer.sv - self-checking bench for first_stage_quadrant_writer
module tb_first_stage_quadrant_writer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  quadrant = 2'd0;
  logic [15:0] product_data = 16'd0;
  logic        product_valid = 1'b0;
  logic        product_ready;
  logic [11:0] write_address;
  logic [15:0] write_data;
  logic        write_en;
  logic        busy;
  logic        done;

  first_stage_quadrant_writer dut (
    .clock         (clock),
    .clear         (clear),
    .start         (start),
    .quadrant      (quadrant),
    .product_data  (product_data),
    .product_valid (product_valid),
    .product_ready (product_ready),
    .write_address (write_address),
    .write_data    (write_data),
    .write_en      (write_en),
    .busy          (busy),
    .done          (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  quad;
    logic [15:0] value;
    bit          stall;
    logic [15:0] exp_data;
    logic [11:0] exp_first;
    logic [11:0] exp_last;
  } case_t;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] data;
    logic        last;
  } exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        sb_q[$];
  bit          sb_on = 1'b0;
  int          writes_seen;
  int          dones_seen;
  logic [11:0] first_seen;
  logic [11:0] last_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (sb_on && write_en) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", 32'(write_address), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("write_address", 32'(write_address), 32'(e.addr));
        check("write_data", 32'(write_data), 32'(e.data));
        check("done_with_write", 32'(done), 32'(e.last));
      end
      if (writes_seen == 0) first_seen = write_address;
      last_seen = write_address;
      writes_seen++;
    end
    if (sb_on && done) begin
      dones_seen++;
      if (!write_en) check("done_without_write", 32'(write_en), 32'd1);
    end
  end

  task automatic start_pass(input logic [1:0] q);
    quadrant = q;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Returns #1 after the clock edge on which the product was accepted.
  task automatic drive_product(input logic [15:0] v, input bit stall);
    int k;
    if (stall) begin
      product_valid = 1'b0;
      @(posedge clock);
      #1;
    end
    product_valid = 1'b1;
    product_data  = v;
    @(negedge clock);
    k = 0;
    while (!product_ready && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (!product_ready) check("ready_timeout", 32'(product_ready), 32'd1);
    @(posedge clock);
    #1;
    product_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(posedge clock);
    #1;
    clear = 1'b1;
    #3;
    clear = 1'b0;
  endtask

  case_t cases[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cases[0] = '{quad: 2'd0, value: 16'd1,      stall: 1'b0, exp_data: 16'd9,     exp_first: 12'h000, exp_last: 12'hC77};
    cases[1] = '{quad: 2'd3, value: 16'd2,      stall: 1'b0, exp_data: 16'd18,    exp_first: 12'h088, exp_last: 12'hCFF};
    cases[2] = '{quad: 2'd1, value: 16'd16000,  stall: 1'b0, exp_data: 16'h7FFF,  exp_first: 12'h008, exp_last: 12'hC7F};
`ifdef FIRST_STAGE_RELU_EN
    cases[3] = '{quad: 2'd2, value: -16'sd16000, stall: 1'b1, exp_data: 16'h0000, exp_first: 12'h080, exp_last: 12'hCF7};
`else
    cases[3] = '{quad: 2'd2, value: -16'sd16000, stall: 1'b1, exp_data: 16'h8000, exp_first: 12'h080, exp_last: 12'hCF7};
`endif
    cases[4] = '{quad: 2'd0, value: 16'd1,      stall: 1'b1, exp_data: 16'd9,     exp_first: 12'h000, exp_last: 12'hC77};

    // Reset, then valid products without start must be ignored.
    clear = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b0;
    product_valid = 1'b1;
    product_data  = 16'd5;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("idle_ready", 32'(product_ready), 32'd0);
    check("idle_write_en", 32'(write_en), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_addr", 32'(write_address), 32'd0);
    check("idle_data", 32'(write_data), 32'd0);
    product_valid = 1'b0;

    // Full passes through the scoreboard.
    for (int i = 0; i < 5; i++) begin
      int k;
      writes_seen = 0;
      dones_seen  = 0;
      sb_on = 1'b1;
      start_pass(cases[i].quad);
      for (int v = 0; v < 4; v++)
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            for (int e = 0; e < 9; e++) begin
              if (e == 8) begin
                exp_t x;
                x.addr = {2'(v), 2'b00, 4'((cases[i].quad[1] ? 8 : 0) + r), 4'((cases[i].quad[0] ? 8 : 0) + c)};
                x.data = cases[i].exp_data;
                x.last = (v == 3 && r == 7 && c == 7);
                sb_q.push_back(x);
              end
              drive_product(cases[i].value, cases[i].stall);
            end
      k = 0;
      while (dones_seen == 0 && k < 10) begin
        @(posedge clock);
        #1;
        k++;
      end
      @(posedge clock);
      #1;
      check("busy_after_pass", 32'(busy), 32'd0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      sb_on = 1'b0;
      check("write_count", 32'(writes_seen), 32'd256);
      check("done_count", 32'(dones_seen), 32'd1);
      check("queue_empty", 32'(sb_q.size()), 32'd0);
      check("first_addr", 32'(first_seen), 32'(cases[i].exp_first));
      check("last_addr", 32'(last_seen), 32'(cases[i].exp_last));
      sb_q.delete();
    end

    // Write latency: the write appears one cycle after the ninth accept.
    start_pass(2'd0);
    for (int e = 0; e < 8; e++) begin
      drive_product(16'd3, 1'b0);
      check("no_early_write", 32'(write_en), 32'd0);
    end
    drive_product(-16'sd1, 1'b0);
    check("latency_write_en", 32'(write_en), 32'd1);
    check("latency_addr", 32'(write_address), 32'h000);
    check("latency_data", 32'(write_data), 32'd23);
    // Next pixel starts back-to-back; its first product is accepted while the write is up.
    check("b2b_ready", 32'(product_ready), 32'd1);

    // Continue to 40 accepts, then clear mid-pass.
    for (int e = 0; e < 31; e++) drive_product(16'd1, 1'b0);
    clear = 1'b1;
    #1;
    check("clear_busy", 32'(busy), 32'd0);
    check("clear_ready", 32'(product_ready), 32'd0);
    check("clear_write_en", 32'(write_en), 32'd0);
    #2;
    clear = 1'b0;
    product_valid = 1'b1;
    product_data  = 16'd1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (write_en) check("write_after_clear", 32'(write_en), 32'd0);
    end
    check("post_clear_busy", 32'(busy), 32'd0);
    product_valid = 1'b0;
    @(posedge clock);
    #1;

    // New pass on quadrant 1 starts cleanly from the first pixel.
    start_pass(2'd1);
    for (int e = 0; e < 9; e++) drive_product(16'd1, 1'b0);
    check("restart_write_en", 32'(write_en), 32'd1);
    check("restart_addr", 32'(write_address), 32'h008);
    check("restart_data", 32'(write_data), 32'd9);
    do_clear();

    // Start is ignored while a pass is running.
    start_pass(2'd0);
    quadrant = 2'd3;
    start = 1'b1;
    drive_product(16'd1, 1'b0);
    start = 1'b0;
    for (int e = 0; e < 8; e++) drive_product(16'd1, 1'b0);
    check("start_ignored_addr", 32'(write_address), 32'h000);
    check("start_ignored_data", 32'(write_data), 32'd9);
    do_clear();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
